// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: feeds operands LSB-first through one
// add/sub bit slice with a registered carry and collects the serial result.
module serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             mode;
  logic             c;
  logic [CNT_W-1:0] cnt;

  // Add/sub bit slice on the current LSBs of the operand shift registers
  logic bx_c;
  logic sum_c;
  logic c_nxt_c;

  assign bx_c    = sh_b[0] ^ mode;
  assign sum_c   = sh_a[0] ^ bx_c ^ c;
  assign c_nxt_c = (sh_a[0] & bx_c) | (sh_a[0] & c) | (bx_c & c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      mode  <= 1'b0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            mode  <= m;
            c     <= m;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          res  <= {sum_c, res[WIDTH-1:1]};
          c    <= c_nxt_c;
          cnt  <= cnt + CNT_W'(1);
          // Last bit: publish result; c is still the carry into the MSB here
          if (cnt == LAST_BIT) begin
            s     <= {sum_c, res[WIDTH-1:1]};
            cout  <= c_nxt_c;
            ovf   <= c ^ c_nxt_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
